// File: rtl/psram_byte_port.sv
// Byte-wide request adapter in front of the HS PSRAM IP (BL16, 4 x 64-bit beats).
// It issues one IP command per request, keeps commands TCMD apart and reports read bytes with their latency.
module psram_byte_port #(
    parameter int ADDR_WIDTH  = 21,
    parameter int TCMD        = 14,
    parameter int BURST_BEATS = 4,
    parameter int RD_TIMEOUT  = 63
) (
    input  logic                  clk,
    input  logic                  sys_resetn,
    input  logic                  calib,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_lane,
    input  logic [7:0]            req_wdata,
    output logic                  resp_valid,
    output logic [7:0]            resp_rdata,
    output logic                  resp_err,
    output logic [5:0]            resp_latency,
    output logic                  cmd,
    output logic                  cmd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [63:0]           wr_data,
    output logic [7:0]            data_mask,
    input  logic [63:0]           rd_data,
    input  logic                  rd_data_valid
);

    localparam int BW = $clog2(BURST_BEATS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_e;

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d, cnt_inc;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  done_q, done_d;
    logic [2:0]            lane_q, lane_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [7:0]            resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [5:0]            resp_latency_q, resp_latency_d;
    logic                  cmd_q, cmd_d;
    logic                  cmd_en_q, cmd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]           wr_data_q, wr_data_d;
    logic [7:0]            data_mask_q, data_mask_d;
    logic                  accept, last_beat, timeout;

    assign accept    = req_valid && req_ready_q;
    assign cnt_inc   = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
    // done_q marks a finished burst that is only waiting out the command spacing.
    assign last_beat = (state_q == READ) && !done_q && rd_data_valid
                       && (beat_q == BW'(BURST_BEATS - 1));
    assign timeout   = (state_q == READ) && !done_q && !last_beat
                       && (cnt_q >= 6'(RD_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            beat_q         <= '0;
            done_q         <= 1'b0;
            lane_q         <= '0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_err_q     <= 1'b0;
            resp_latency_q <= '0;
            cmd_q          <= 1'b0;
            cmd_en_q       <= 1'b0;
            addr_q         <= '0;
            wr_data_q      <= '0;
            data_mask_q    <= 8'hff;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            beat_q         <= beat_d;
            done_q         <= done_d;
            lane_q         <= lane_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            resp_latency_q <= resp_latency_d;
            cmd_q          <= cmd_d;
            cmd_en_q       <= cmd_en_d;
            addr_q         <= addr_d;
            wr_data_q      <= wr_data_d;
            data_mask_q    <= data_mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_write ? WRITE : READ;
            WRITE:   if (cnt_q >= 6'(TCMD - 1)) state_d = IDLE;
            READ:    if (timeout || ((done_q || last_beat) && cnt_q >= 6'(TCMD - 1))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d          = cnt_inc;
        beat_d         = beat_q;
        done_d         = done_q;
        lane_d         = lane_q;
        req_ready_d    = calib && (state_d == IDLE);
        resp_valid_d   = 1'b0;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        resp_latency_d = resp_latency_q;
        cmd_d          = cmd_q;
        cmd_en_d       = 1'b0;
        addr_d         = addr_q;
        wr_data_d      = wr_data_q;
        data_mask_d    = data_mask_q;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (accept) begin
                    cmd_en_d = 1'b1;
                    cmd_d    = req_write;
                    addr_d   = req_addr;
                    cnt_d    = 6'd1;
                    lane_d   = req_lane;
                    beat_d   = '0;
                    done_d   = 1'b0;
                    if (req_write) begin
                        wr_data_d   = 64'(req_wdata) << {req_lane, 3'b000};
                        data_mask_d = ~(8'h01 << req_lane);
                    end else begin
                        data_mask_d = 8'h00;
                    end
                end
            end
            WRITE: data_mask_d = 8'hff;
            READ: begin
                if (rd_data_valid && !done_q) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == '0) resp_rdata_d = rd_data[{lane_q, 3'b000} +: 8];
                end
                if (last_beat) begin
                    resp_valid_d   = 1'b1;
                    resp_err_d     = 1'b0;
                    resp_latency_d = cnt_q;
                    done_d         = 1'b1;
                end else if (timeout) begin
                    resp_valid_d   = 1'b1;
                    resp_err_d     = 1'b1;
                    resp_latency_d = 6'(RD_TIMEOUT);
                end
            end
            default: ;
        endcase
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign resp_latency = resp_latency_q;
    assign cmd          = cmd_q;
    assign cmd_en       = cmd_en_q;
    assign addr         = addr_q;
    assign wr_data      = wr_data_q;
    assign data_mask    = data_mask_q;

endmodule
